id_hazard_ctrl: RTL and testbench
=================================

# id_hazard_ctrl

Parametrised register-hazard controller for the decode stage. Tracks outstanding register writes with a per-register pending-write scoreboard. Forwards operands from any number of downstream producer stages and computes `ds_ready_go`. Replaces the fixed EX/MEM/WB compare chain and load-only stall. Covers producers whose data is not yet valid (loads, multi-cycle mul/div) and producers that are in flight but not visible on any forwarding port.

## Interface
Parameters:
- `NUM_FWD`, 3: number of forwarding ports; index 0 = youngest (EX), index NUM_FWD-1 = oldest (WB).
- `DATA_W`, 32: operand width.
- `PEND_W`, 2: pending-counter width per register; max outstanding writes per register = 2^PEND_W-1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `ds_valid` in 1: decode holds a valid instruction.
- `src1_used`, `src2_used` in 1 each: operand is actually read (not pc/imm).
- `src1_addr`, `src2_addr` in 5 each: source register numbers.
- `rf_rdata1`, `rf_rdata2` in DATA_W each: regfile read data.
- `fwd_valid` in NUM_FWD: stage holds a valid instruction.
- `fwd_we` in NUM_FWD: stage will write a GPR.
- `fwd_dest` in 5*NUM_FWD: destination per stage; port i is at bits [5i+4:5i].
- `fwd_data_ok` in NUM_FWD: the stage's result is final this cycle.
- `fwd_data` in DATA_W*NUM_FWD: result per stage.
- `issue` in 1: decode fires this cycle (ds_valid & ds_ready_go & es_allowin).
- `issue_we` in 1, `issue_dest` in 5: the issuing instruction writes this register.
- `retire` in 1, `retire_dest` in 5: one register write completes (WB commit).
- `ds_ready_go` out 1: no unresolved hazard.
- `src1_value`, `src2_value` out DATA_W each: resolved operands.
- `sb_overflow` out 1: sticky error flag.
- `perf_stall_cnt` out 32: stall-cycle counter (see Configuration).

## Operation
- Scoreboard: `pend[r]` for r = 1..31; r0 is never tracked and always reads 0.
- Increment `pend[issue_dest]` on `issue & issue_we & issue_dest!=0`.
- Decrement `pend[retire_dest]` on `retire & retire_dest!=0`.
- Issue and retire to the same register in one cycle leave the count unchanged.
- Retire to a register with `pend==0` is ignored and sets `sb_overflow`.
- Increment at max saturates and sets `sb_overflow`.
- Every issued instruction with `issue_we` must produce exactly one retire pulse, including cancelled writes. Flushes of downstream stages do not touch the scoreboard.
- Operand resolution runs per source s, evaluated combinationally in order:
  1. `!srcS_used` or addr==0: value = rf_rdata, no hazard.
  2. Otherwise find the lowest port index i with `fwd_valid[i] & fwd_we[i] & fwd_dest[i]==addr`.
     - Hit with `fwd_data_ok[i]`: value = fwd_data[i].
     - Hit without `fwd_data_ok[i]`: hazard.
  3. No hit and `pend[addr]!=0`: hazard. The producer is in flight in a non-forwarding unit.
  4. No hit and `pend[addr]==0`: value = rf_rdata.
- `ds_ready_go = ~ds_valid | ~(hazard1 | hazard2)`.
- When there is a hazard, the operand value is don't-care.

## Timing
- Forwarding and `ds_ready_go` are purely combinational from inputs and current `pend`. Zero-cycle latency.
- Scoreboard and flags update on the `clk` rising edge.
- Issue at cycle t makes the dest pending from t+1.
- A retire at cycle t clears pending from t+1. During cycle t the WB forwarding port supplies the data, so there is no bubble.
- Async reset: all `pend`=0, `sb_overflow`=0, `perf_stall_cnt`=0. Outputs settle from the cleared state within the same cycle.
- Reset mid-operation: all outstanding writes are discarded. The environment must flush the pipeline concurrently.

## Configuration
- `HAZARD_PERF_EN`
  - Defined: `perf_stall_cnt` increments every cycle with `ds_valid & ~ds_ready_go`. It wraps at 2^32 and is cleared by reset.
  - Undefined: no counter register; `perf_stall_cnt` is tied to 0.

## Test plan
- ALU chain: issue `add r5` (EX: valid, we, dest 5, data_ok, data 0x11), then decode reads r5 → `ds_ready_go`=1, `src1_value`=0x11.
- Load-use: EX port has dest 7, `data_ok`=0; decode reads r7 via src2 → `ds_ready_go`=0.
  - Next cycle the load is in MEM with `data_ok`=1, data 0xABCD → `ds_ready_go`=1, `src2_value`=0xABCD.
- Youngest wins: EX dest 3 data 0x1 and MEM dest 3 data 0x2, both ok → `src1_value`=0x1.
- Invisible producer: issue a div to r9 (`pend[9]`=1) with no fwd port matching r9 → stall for N cycles.
  - Retire r9 with WB port data 0x99 → `ds_ready_go`=1 that cycle, `src1_value`=0x99; `pend[9]`=0 next cycle.
- r0 and unused sources: `src1_addr`=0 with a matching EX dest 0 not ok; `src2_used`=0 with `pend` set → `ds_ready_go`=1, values = rf_rdata.
- Boundaries:
  - Issue r4 three times (PEND_W=2) then once more → `sb_overflow`=1.
  - Simultaneous issue+retire r4 → count holds.
  - Assert reset mid-stream → all `pend` clear, `perf_stall_cnt`=0.
  - With `HAZARD_PERF_EN`, 5 stall cycles → `perf_stall_cnt`=5.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// id_hazard_ctrl
//
// Register-hazard controller for the decode stage. It keeps a per-register
// pending-write count and resolves both source operands against any number
// of downstream forwarding ports. The result is a combinational ds_ready_go
// and the two resolved operand values.
//
// Parameters
//   NUM_FWD : number of forwarding ports (0 = youngest/EX, NUM_FWD-1 = oldest/WB)
//   DATA_W  : operand width
//   PEND_W  : pending-counter width; saturates at 2^PEND_W-1 outstanding writes
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   ds_valid              : decode holds a valid instruction
//   src{1,2}_used/_addr   : operand is read / its register number
//   rf_rdata{1,2}         : regfile read data
//   fwd_valid/we/dest/data_ok/data : per-port producer info (port i at slice i)
//   issue, issue_we, issue_dest    : decode fires and will write issue_dest
//   retire, retire_dest            : one register write commits
//   ds_ready_go           : no unresolved hazard
//   src{1,2}_value        : resolved operands (don't-care under hazard)
//   sb_overflow           : sticky scoreboard error (saturate / underflow)
//   perf_stall_cnt        : stall-cycle counter
//
// Optional feature
//   HAZARD_PERF_EN : when defined, perf_stall_cnt counts cycles with
//                    ds_valid & ~ds_ready_go (wraps, cleared by reset);
//                    otherwise it is tied to zero and no register exists.
// ---------------------------------------------------------------------------
module id_hazard_ctrl #(
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = 32,
  parameter int PEND_W  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ds_valid,
  input  logic                      src1_used,
  input  logic                      src2_used,
  input  logic [4:0]                src1_addr,
  input  logic [4:0]                src2_addr,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [5*NUM_FWD-1:0]      fwd_dest,
  input  logic [NUM_FWD-1:0]        fwd_data_ok,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_data,
  input  logic                      issue,
  input  logic                      issue_we,
  input  logic [4:0]                issue_dest,
  input  logic                      retire,
  input  logic [4:0]                retire_dest,
  output logic                      ds_ready_go,
  output logic [DATA_W-1:0]         src1_value,
  output logic [DATA_W-1:0]         src2_value,
  output logic                      sb_overflow,
  output logic [31:0]               perf_stall_cnt
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // Entry 0 is never written, so it stays zero and r0 never looks pending.
  logic [PEND_W-1:0] pend     [32];
  logic [PEND_W-1:0] pend_nxt [32];
  logic              ovf_evt;

  logic              inc_en;
  logic              dec_en;

  // Per-source working signals, index 0 = src1, 1 = src2.
  logic              src_used  [2];
  logic [4:0]        src_addr  [2];
  logic [DATA_W-1:0] src_rdata [2];
  logic              hit       [2];
  logic              hit_ok    [2];
  logic [DATA_W-1:0] hit_data  [2];
  logic              hazard    [2];
  logic [DATA_W-1:0] value     [2];

  // -------------------------------------------------------------------------
  // Scoreboard next-state
  // -------------------------------------------------------------------------
  assign inc_en = issue & issue_we & (issue_dest != 5'd0);
  assign dec_en = retire & (retire_dest != 5'd0);

  always_comb begin
    pend_nxt = pend;
    ovf_evt  = 1'b0;
    for (int unsigned r = 1; r < 32; r++) begin
      if (inc_en && (issue_dest == 5'(r)) && dec_en && (retire_dest == 5'(r))) begin
        // One write enters while another leaves: the count is unchanged.
        pend_nxt[r] = pend[r];
      end else if (inc_en && (issue_dest == 5'(r))) begin
        if (pend[r] == PEND_MAX) begin
          ovf_evt = 1'b1;
        end else begin
          pend_nxt[r] = pend[r] + 1'b1;
        end
      end else if (dec_en && (retire_dest == 5'(r))) begin
        if (pend[r] == '0) begin
          ovf_evt = 1'b1;
        end else begin
          pend_nxt[r] = pend[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend        <= '{default: '0};
      sb_overflow <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (ovf_evt) begin
        sb_overflow <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Operand resolution
  // -------------------------------------------------------------------------
  always_comb begin
    src_used[0]  = src1_used;
    src_used[1]  = src2_used;
    src_addr[0]  = src1_addr;
    src_addr[1]  = src2_addr;
    src_rdata[0] = rf_rdata1;
    src_rdata[1] = rf_rdata2;
  end

  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      hit[s]      = 1'b0;
      hit_ok[s]   = 1'b0;
      hit_data[s] = '0;
      hazard[s]   = 1'b0;
      value[s]    = src_rdata[s];
      if (src_used[s] && (src_addr[s] != 5'd0)) begin
        // Upward scan latching only the first match gives the youngest
        // producer priority over older ones.
        for (int unsigned i = 0; i < NUM_FWD; i++) begin
          if (!hit[s] && fwd_valid[i] && fwd_we[i] &&
              (fwd_dest[5*i +: 5] == src_addr[s])) begin
            hit[s]      = 1'b1;
            hit_ok[s]   = fwd_data_ok[i];
            hit_data[s] = fwd_data[DATA_W*i +: DATA_W];
          end
        end
        if (hit[s]) begin
          if (hit_ok[s]) begin
            value[s] = hit_data[s];
          end else begin
            hazard[s] = 1'b1;
          end
        end else if (pend[src_addr[s]] != '0) begin
          // Producer is in flight somewhere without a forwarding port.
          hazard[s] = 1'b1;
        end
      end
    end
  end

  assign src1_value  = value[0];
  assign src2_value  = value[1];
  assign ds_ready_go = ~ds_valid | ~(hazard[0] | hazard[1]);

  // -------------------------------------------------------------------------
  // Stall-cycle counter
  // -------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (ds_valid && !ds_ready_go) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_id_hazard_ctrl
//
// Directed bench for id_hazard_ctrl. Each step drives inputs on the falling
// edge, pushes its expected outputs into a queue, then pops and compares
// them mid-low-phase; the rising edge that follows advances the scoreboard.
// ---------------------------------------------------------------------------
module tb_id_hazard_ctrl;

  localparam int NF = 3;
  localparam int DW = 32;
  localparam int PW = 2;

  localparam logic [DW-1:0] RF1 = 32'h1111_1111;
  localparam logic [DW-1:0] RF2 = 32'h2222_2222;

  logic              clk;
  logic              reset;
  logic              ds_valid;
  logic              src1_used, src2_used;
  logic [4:0]        src1_addr, src2_addr;
  logic [DW-1:0]     rf_rdata1, rf_rdata2;
  logic [NF-1:0]     fwd_valid, fwd_we, fwd_data_ok;
  logic [5*NF-1:0]   fwd_dest;
  logic [DW*NF-1:0]  fwd_data;
  logic              issue, issue_we;
  logic [4:0]        issue_dest;
  logic              retire;
  logic [4:0]        retire_dest;
  logic              ds_ready_go;
  logic [DW-1:0]     src1_value, src2_value;
  logic              sb_overflow;
  logic [31:0]       perf_stall_cnt;

  typedef struct {
    string         tag;
    logic          rdy;
    logic          ovf;
    bit            c1;
    logic [DW-1:0] v1;
    bit            c2;
    logic [DW-1:0] v2;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  id_hazard_ctrl #(.NUM_FWD(NF), .DATA_W(DW), .PEND_W(PW)) dut (
    .clk            (clk),
    .reset          (reset),
    .ds_valid       (ds_valid),
    .src1_used      (src1_used),
    .src2_used      (src2_used),
    .src1_addr      (src1_addr),
    .src2_addr      (src2_addr),
    .rf_rdata1      (rf_rdata1),
    .rf_rdata2      (rf_rdata2),
    .fwd_valid      (fwd_valid),
    .fwd_we         (fwd_we),
    .fwd_dest       (fwd_dest),
    .fwd_data_ok    (fwd_data_ok),
    .fwd_data       (fwd_data),
    .issue          (issue),
    .issue_we       (issue_we),
    .issue_dest     (issue_dest),
    .retire         (retire),
    .retire_dest    (retire_dest),
    .ds_ready_go    (ds_ready_go),
    .src1_value     (src1_value),
    .src2_value     (src2_value),
    .sb_overflow    (sb_overflow),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ds_valid    = 1'b0;
    src1_used   = 1'b0;
    src2_used   = 1'b0;
    src1_addr   = 5'd0;
    src2_addr   = 5'd0;
    rf_rdata1   = RF1;
    rf_rdata2   = RF2;
    fwd_valid   = '0;
    fwd_we      = '0;
    fwd_dest    = '0;
    fwd_data_ok = '0;
    fwd_data    = '0;
    issue       = 1'b0;
    issue_we    = 1'b0;
    issue_dest  = 5'd0;
    retire      = 1'b0;
    retire_dest = 5'd0;
  endtask

  task automatic set_fwd(input int i, input logic [4:0] dest, input logic ok,
                         input logic [DW-1:0] data);
    fwd_valid[i]          = 1'b1;
    fwd_we[i]             = 1'b1;
    fwd_dest[5*i +: 5]    = dest;
    fwd_data_ok[i]        = ok;
    fwd_data[DW*i +: DW]  = data;
  endtask

  task automatic rd1(input logic [4:0] a);
    ds_valid  = 1'b1;
    src1_used = 1'b1;
    src1_addr = a;
  endtask

  task automatic rd2(input logic [4:0] a);
    ds_valid  = 1'b1;
    src2_used = 1'b1;
    src2_addr = a;
  endtask

  task automatic do_issue(input logic [4:0] d);
    issue      = 1'b1;
    issue_we   = 1'b1;
    issue_dest = d;
  endtask

  task automatic do_retire(input logic [4:0] d);
    retire      = 1'b1;
    retire_dest = d;
  endtask

  // Push expectation, compare shortly after inputs settle, then move to the
  // next falling edge (the rising edge in between commits state).
  task automatic step(input string tag, input logic rdy, input logic ovf,
                      input bit c1, input logic [DW-1:0] v1,
                      input bit c2, input logic [DW-1:0] v2);
    exp_t e;
    e.tag = tag; e.rdy = rdy; e.ovf = ovf;
    e.c1 = c1; e.v1 = v1; e.c2 = c2; e.v2 = v2;
    exp_q.push_back(e);
    #2;
    e = exp_q.pop_front();
    chk({e.tag, ".rdy"}, 64'(ds_ready_go), 64'(e.rdy));
    chk({e.tag, ".ovf"}, 64'(sb_overflow), 64'(e.ovf));
    if (e.c1) chk({e.tag, ".v1"}, 64'(src1_value), 64'(e.v1));
    if (e.c2) chk({e.tag, ".v2"}, 64'(src2_value), 64'(e.v2));
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    reset = 1'b1;
    @(negedge clk);

    // Reset state
    idle(); rd1(5'd4);
    step("rst", 1'b1, 1'b0, 1'b1, RF1, 1'b0, '0);
    chk("rst.perf", 64'(perf_stall_cnt), 64'd0);
    reset = 1'b0;

    // ALU chain
    idle(); do_issue(5'd5);
    step("alu_issue", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    idle(); rd1(5'd5); set_fwd(0, 5'd5, 1'b1, 32'h11);
    step("alu_fwd", 1'b1, 1'b0, 1'b1, 32'h11, 1'b0, '0);
    idle(); rd1(5'd5);
    step("alu_pend", 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    idle(); rd1(5'd5); set_fwd(2, 5'd5, 1'b1, 32'h11); do_retire(5'd5);
    step("alu_retire", 1'b1, 1'b0, 1'b1, 32'h11, 1'b0, '0);
    idle(); rd1(5'd5);
    step("alu_clear", 1'b1, 1'b0, 1'b1, RF1, 1'b0, '0);

    // Load-use
    idle(); rd2(5'd7); set_fwd(0, 5'd7, 1'b0, 32'hdead);
    step("ld_use", 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    idle(); rd2(5'd7); set_fwd(1, 5'd7, 1'b1, 32'hABCD);
    step("ld_mem", 1'b1, 1'b0, 1'b0, '0, 1'b1, 32'hABCD);

    // Youngest wins, including a young not-ready producer masking an old one
    idle(); rd1(5'd3); set_fwd(0, 5'd3, 1'b1, 32'h1); set_fwd(1, 5'd3, 1'b1, 32'h2);
    step("young", 1'b1, 1'b0, 1'b1, 32'h1, 1'b0, '0);
    idle(); rd1(5'd3); set_fwd(0, 5'd3, 1'b0, 32'h1); set_fwd(1, 5'd3, 1'b1, 32'h2);
    step("young_nok", 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

    // Invisible producer
    idle(); do_issue(5'd9);
    step("div_issue", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      idle(); rd1(5'd9);
      step("div_stall", 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    end
    idle(); src1_used = 1'b1; src1_addr = 5'd9;
    step("div_noval", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    idle(); rd1(5'd9); set_fwd(2, 5'd9, 1'b1, 32'h99); do_retire(5'd9);
    step("div_retire", 1'b1, 1'b0, 1'b1, 32'h99, 1'b0, '0);
    idle(); rd1(5'd9);
    step("div_clear", 1'b1, 1'b0, 1'b1, RF1, 1'b0, '0);

    // r0 and unused source
    idle(); do_issue(5'd12);
    step("r0_issue", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    idle(); rd1(5'd0); set_fwd(0, 5'd0, 1'b0, 32'h5);
    src2_used = 1'b0; src2_addr = 5'd12;
    step("r0_unused", 1'b1, 1'b0, 1'b1, RF1, 1'b1, RF2);
    idle(); do_retire(5'd12);
    step("r0_retire", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);

    // Saturation, then simultaneous issue+retire holding the count
    for (int k = 0; k < 3; k++) begin
      idle(); do_issue(5'd4);
      step("sat_issue", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    end
    idle(); rd2(5'd4); do_issue(5'd4);
    step("sat_issue4", 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    idle(); rd2(5'd4); do_issue(5'd4); do_retire(5'd4);
    step("sat_ovf", 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      idle(); rd2(5'd4); do_retire(5'd4);
      step("sat_drain", 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    end
    idle(); rd2(5'd4);
    step("sat_empty", 1'b1, 1'b1, 1'b0, '0, 1'b1, RF2);

    // Reset mid-stream
    idle(); do_issue(5'd9);
    step("mid_issue", 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    idle(); rd1(5'd9);
    step("mid_stall", 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    idle(); rd1(5'd9);
    reset = 1'b1;
    step("mid_rst", 1'b1, 1'b0, 1'b1, RF1, 1'b0, '0);
    chk("mid_rst.perf", 64'(perf_stall_cnt), 64'd0);
    reset = 1'b0;

    // Retire with nothing pending
    idle(); do_retire(5'd20);
    step("under", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    idle();
    step("under_ovf", 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);

    // Five stall cycles
    idle(); do_issue(5'd10);
    step("perf_issue", 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      idle(); rd2(5'd10);
      step("perf_stall", 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    end
    idle();
`ifdef HAZARD_PERF_EN
    chk("perf5", 64'(perf_stall_cnt), 64'd5);
`else
    chk("perf_off", 64'(perf_stall_cnt), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
